pulse_gen: RTL and testbench

PULSE_GEN -- requirements
Module: pulse_gen

---
 rtl/pulse_gen.sv | 91 +++++++++
 tb/tb_pulse_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen.sv
// Multi-channel pulse generator.
// Each channel runs a programmable period/high-time waveform, either continuously or as a one-shot.
module pulse_gen #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS*WIDTH-1:0] period,
  input  logic [CHANNELS*WIDTH-1:0] high,
  output logic [CHANNELS-1:0]       signal,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       wrap
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] per_in;
    logic [WIDTH-1:0] high_in;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             sig_q, sig_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] cnt_inc;
    logic             last;
    logic             start_run;
    logic             reload;
    logic             load;

    assign per_in  = period[g*WIDTH +: WIDTH];
    assign high_in = high[g*WIDTH +: WIDTH];
    assign cnt_inc = cnt_q + WIDTH'(1);
    assign last    = (cnt_q == per_q - WIDTH'(1));

    // A fresh period starts either from IDLE or at a continuous-mode wrap edge;
    // both sample the live period/high inputs into the shadow registers.
    assign start_run = (state_q == IDLE) && enable[g] && (per_in != '0) && (!mode[g] || start[g]);
    assign reload    = (state_q == RUN) && enable[g] && last && !mode[g] && (per_in != '0);
    assign load      = start_run || reload;

    always_comb begin
      state_d = IDLE;
      cnt_d   = '0;
      per_d   = per_q;
      high_d  = high_q;
      sig_d   = 1'b0;
      wrap_d  = 1'b0;
      if (load) begin
        state_d = RUN;
        per_d   = per_in;
        high_d  = high_in;
        sig_d   = (high_in != '0);
        wrap_d  = (per_in == WIDTH'(1));
      end else if ((state_q == RUN) && enable[g] && !last) begin
        state_d = RUN;
        cnt_d   = cnt_inc;
        sig_d   = (cnt_inc < high_q);
        wrap_d  = (cnt_inc == per_q - WIDTH'(1));
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        per_q   <= '0;
        high_q  <= '0;
        sig_q   <= 1'b0;
        wrap_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        per_q   <= per_d;
        high_q  <= high_d;
        sig_q   <= sig_d;
        wrap_q  <= wrap_d;
      end
    end

    assign signal[g] = sig_q;
    assign busy[g]   = (state_q == RUN);
    assign wrap[g]   = wrap_q;
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: vector table, corner-case sequences and random stimulus
// checked against a period/position model of each channel.
module tb_pulse_gen;

  logic        clock;
  logic        reset;
  logic [1:0]  enable, mode, start;
  logic [15:0] period, high;
  logic [1:0]  signal, busy, wrap;

  logic [0:0]  en4, md4, st4;
  logic [3:0]  per4, hi4;
  logic [0:0]  sig4, busy4, wrap4;

  int total = 0;
  int bad   = 0;

  pulse_gen #(.CHANNELS(2), .WIDTH(8)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .start(start),
    .period(period), .high(high), .signal(signal), .busy(busy), .wrap(wrap)
  );

  pulse_gen #(.CHANNELS(1), .WIDTH(4)) u_dut4 (
    .clock(clock), .reset(reset), .enable(en4), .mode(md4), .start(st4),
    .period(per4), .high(hi4), .signal(sig4), .busy(busy4), .wrap(wrap4)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: a running channel sits at position pos within a period of per cycles
  typedef struct {
    bit run;
    int pos;
    int per;
    int hi;
  } ch_t;

  ch_t m[2];
  ch_t m4;

  function automatic ch_t step(ch_t c, bit en, bit md, bit st, int pin, int hin);
    ch_t n = c;
    if (!c.run) begin
      if (en && pin != 0 && (!md || st)) begin
        n.run = 1; n.pos = 0; n.per = pin; n.hi = hin;
      end
    end else if (!en) begin
      n.run = 0; n.pos = 0;
    end else if (c.pos == c.per - 1) begin
      if (md || pin == 0) begin
        n.run = 0; n.pos = 0;
      end else begin
        n.pos = 0; n.per = pin; n.hi = hin;
      end
    end else begin
      n.pos = c.pos + 1;
    end
    return n;
  endfunction

  function automatic logic [2:0] outs(ch_t c);
    return {c.run && (c.pos < c.hi), c.run, c.run && (c.pos == c.per - 1)};
  endfunction

  function automatic ch_t idle_ch();
    ch_t c;
    c.run = 0; c.pos = 0; c.per = 0; c.hi = 0;
    return c;
  endfunction

  // scoreboard
  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_main(string nm);
    logic [2:0] e0, e1;
    e0 = outs(m[0]);
    e1 = outs(m[1]);
    cmp(nm, 32'({signal, busy, wrap}), 32'({e1[2], e0[2], e1[1], e0[1], e1[0], e0[0]}));
  endtask

  task automatic check_w4(string nm);
    cmp(nm, 32'({sig4, busy4, wrap4}), 32'(outs(m4)));
  endtask

  // driver
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 2; i++)
        m[i] = step(m[i], enable[i], mode[i], start[i], int'(period[i*8 +: 8]), int'(high[i*8 +: 8]));
      m4 = step(m4, en4[0], md4[0], st4[0], int'(per4), int'(hi4));
    end
    #1;
  endtask

  task automatic clear_inputs();
    enable = '0; mode = '0; start = '0; period = '0; high = '0;
    en4 = '0; md4 = '0; st4 = '0; per4 = '0; hi4 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    m[0] = idle_ch(); m[1] = idle_ch(); m4 = idle_ch();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // vector table for channel 0 (channel 1 held disabled)
  typedef struct {
    logic       en, md, st;
    logic [7:0] per, hi;
    logic       s, b, w;
  } vec_t;

  vec_t vecs[$];

  task automatic add(logic en, logic md, logic st, logic [7:0] per, logic [7:0] hi,
                     logic s, logic b, logic w);
    vec_t v;
    v.en = en; v.md = md; v.st = st; v.per = per; v.hi = hi; v.s = s; v.b = b; v.w = w;
    vecs.push_back(v);
  endtask

  int sum_s, sum_b, sum_w, coincide, first_co, last_w, first_w;

  initial begin
    clear_inputs();
    reset = 1'b0;
    m[0] = idle_ch(); m[1] = idle_ch(); m4 = idle_ch();
    #12;
    cmp("reset main", 32'({signal, busy, wrap}), 32'd0);
    cmp("reset w4", 32'({sig4, busy4, wrap4}), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // continuous 4/2
    for (int k = 0; k < 2; k++) begin
      add(1, 0, 0, 4, 2, 1, 1, 0); add(1, 0, 0, 4, 2, 1, 1, 0);
      add(1, 0, 0, 4, 2, 0, 1, 0); add(1, 0, 0, 4, 2, 0, 1, 1);
    end
    add(1, 0, 0, 4, 2, 1, 1, 0); add(1, 0, 0, 4, 2, 1, 1, 0);
    // period 4->8 at cnt 2: current period still ends after 4
    add(1, 0, 0, 8, 2, 0, 1, 0); add(1, 0, 0, 8, 2, 0, 1, 1);
    add(1, 0, 0, 8, 2, 1, 1, 0); add(1, 0, 0, 8, 2, 1, 1, 0);
    add(1, 0, 0, 8, 2, 0, 1, 0); add(1, 0, 0, 8, 2, 0, 1, 0);
    add(1, 0, 0, 8, 2, 0, 1, 0); add(1, 0, 0, 8, 2, 0, 1, 0);
    add(1, 0, 0, 8, 2, 0, 1, 0); add(1, 0, 0, 8, 3, 0, 1, 1);
    // high 3, abort at cnt 1
    add(1, 0, 0, 8, 3, 1, 1, 0); add(1, 0, 0, 8, 3, 1, 1, 0);
    add(0, 0, 0, 8, 3, 0, 0, 0); add(0, 0, 0, 8, 3, 0, 0, 0);
    // high = 0
    add(1, 0, 0, 3, 0, 0, 1, 0); add(1, 0, 0, 3, 0, 0, 1, 0);
    add(1, 0, 0, 3, 0, 0, 1, 1); add(1, 0, 0, 3, 0, 0, 1, 0);
    add(0, 0, 0, 3, 0, 0, 0, 0);
    // high 9 > period 5
    add(1, 0, 0, 5, 9, 1, 1, 0); add(1, 0, 0, 5, 9, 1, 1, 0);
    add(1, 0, 0, 5, 9, 1, 1, 0); add(1, 0, 0, 5, 9, 1, 1, 0);
    add(1, 0, 0, 5, 9, 1, 1, 1); add(1, 0, 0, 5, 9, 1, 1, 0);
    // period = 0 never starts
    add(0, 0, 0, 5, 9, 0, 0, 0);
    add(1, 0, 0, 0, 3, 0, 0, 0); add(1, 0, 0, 0, 3, 0, 0, 0);
    // period = 1
    add(1, 0, 0, 1, 1, 1, 1, 1); add(1, 0, 0, 1, 1, 1, 1, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0);
    // one-shot on channel 0
    add(1, 1, 0, 3, 1, 0, 0, 0); add(1, 1, 1, 3, 1, 1, 1, 0);
    add(1, 1, 0, 3, 1, 0, 1, 0); add(1, 1, 0, 3, 1, 0, 1, 1);
    add(1, 1, 0, 3, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      enable = {1'b0, vecs[i].en};
      mode   = {1'b0, vecs[i].md};
      start  = {1'b0, vecs[i].st};
      period = {8'd0, vecs[i].per};
      high   = {8'd0, vecs[i].hi};
      tick();
      cmp($sformatf("vec%0d", i), 32'({signal, busy, wrap}),
          32'({1'b0, vecs[i].s, 1'b0, vecs[i].b, 1'b0, vecs[i].w}));
    end

    // one-shot on channel 1 with a second start while busy
    do_reset();
    enable = 2'b10; mode = 2'b10; period = {8'd6, 8'd0}; high = {8'd3, 8'd0};
    sum_s = 0; sum_b = 0; sum_w = 0;
    for (int c = 0; c < 10; c++) begin
      start = {(c == 0 || c == 2), 1'b0};
      tick();
      check_main("oneshot");
      sum_s += int'(signal[1]); sum_b += int'(busy[1]); sum_w += int'(wrap[1]);
    end
    cmp("oneshot high cycles", 32'(sum_s), 32'd3);
    cmp("oneshot busy cycles", 32'(sum_b), 32'd6);
    cmp("oneshot wraps", 32'(sum_w), 32'd1);
    cmp("oneshot ends idle", 32'(busy[1]), 32'd0);

    // independent channels, periods 3 and 5
    do_reset();
    enable = 2'b11; mode = 2'b00; period = {8'd5, 8'd3}; high = {8'd2, 8'd1};
    coincide = 0; first_co = 0;
    for (int c = 1; c <= 31; c++) begin
      tick();
      check_main("indep");
      if (wrap == 2'b11) begin
        coincide++;
        if (first_co == 0) first_co = c;
      end
    end
    cmp("indep coincide count", 32'(coincide), 32'd2);
    cmp("indep first coincide", 32'(first_co), 32'd15);

    // WIDTH=4, period 15
    do_reset();
    en4 = 1'b1; per4 = 4'd15; hi4 = 4'd7;
    last_w = 0; first_w = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      check_w4("w4");
      if (wrap4[0]) begin
        if (last_w != 0) cmp("w4 interval", 32'(c - last_w), 32'd15);
        else first_w = c;
        last_w = c;
      end
    end
    cmp("w4 first wrap", 32'(first_w), 32'd15);
    en4 = 1'b0;

    // asynchronous reset mid-period
    do_reset();
    enable = 2'b01; period = {8'd0, 8'd4}; high = {8'd0, 8'd2};
    tick(); check_main("pre reset");
    tick(); check_main("pre reset");
    #2;
    reset = 1'b0;
    #1;
    cmp("async reset", 32'({signal, busy, wrap}), 32'd0);
    m[0] = idle_ch(); m[1] = idle_ch(); m4 = idle_ch();
    tick(); check_main("reset hold");
    @(negedge clock);
    reset = 1'b1;
    tick(); check_main("post reset start");
    cmp("post reset busy", 32'(busy), 32'd1);

    // random stimulus
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        enable[i] = ($urandom_range(0, 19) != 0);
        if ($urandom_range(0, 15) == 0) mode[i] = ~mode[i];
        start[i] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 5) == 0) period[i*8 +: 8] = 8'($urandom_range(0, 7));
        high[i*8 +: 8] = 8'($urandom_range(0, 9));
      end
      tick();
      check_main("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
